pwm_multi_channel: RTL and testbench



---
 rtl/pwm_multi_channel_if.sv | 28 ++
 rtl/pwm_multi_channel.sv | 153 +++++++++++++++
 tb/tb_pwm_multi_channel.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_channel_if.sv
// Register-bank side of the multi-channel PWM: configuration inputs plus
// the PWM outputs and status pulses.
interface pwm_multi_channel_if #(
  parameter int N       = 8,
  parameter int CH      = 4,
  parameter int PRESC_W = 8
);
  logic               enable;
  logic [PRESC_W-1:0] prescale;
  logic [N-1:0]       period;
  logic               center_mode;
  logic [CH*N-1:0]    duty;
  logic [CH-1:0]      polarity;
  logic               update;
  logic [CH-1:0]      pwm_out;
  logic               period_tick;
  logic               update_ack;

  modport master (
    output enable, prescale, period, center_mode, duty, polarity, update,
    input  pwm_out, period_tick, update_ack
  );

  modport slave (
    input  enable, prescale, period, center_mode, duty, polarity, update,
    output pwm_out, period_tick, update_ack
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with shared prescaled time base, edge/center-aligned
// counting and double-buffered settings that only change at period boundaries.
module pwm_multi_channel #(
  parameter int N       = 8,
  parameter int CH      = 4,
  parameter int PRESC_W = 8
) (
  input logic             clk,
  input logic             reset_n,
  pwm_multi_channel_if.slave bus
);

  typedef enum logic { DIR_UP, DIR_DOWN } dir_e;
  typedef enum logic { MODE_EDGE, MODE_CENTER } mode_e;

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [N-1:0]       cnt_q, cnt_d;
  dir_e               dir_q, dir_d;
  logic               pending_q, pending_d;
  logic [N-1:0]       period_a_q, period_a_d;
  logic [CH*N-1:0]    duty_a_q, duty_a_d;
  logic [CH-1:0]      pol_a_q, pol_a_d;
  mode_e              mode_a_q, mode_a_d;
  logic [CH-1:0]      pwm_out_q, pwm_out_d;
  logic               period_tick_q, period_tick_d;
  logic               update_ack_q, update_ack_d;

  logic               tick;
  logic               boundary;
  logic               load;
  logic [CH-1:0]      raw;

  always_comb begin
    raw = '0;
    for (int k = 0; k < CH; k++) begin
      raw[k] = (cnt_q < duty_a_q[k*N +: N]);
    end
  end

  always_comb begin
    presc_cnt_d   = presc_cnt_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    pending_d     = pending_q;
    period_a_d    = period_a_q;
    duty_a_d      = duty_a_q;
    pol_a_d       = pol_a_q;
    mode_a_d      = mode_a_q;
    pwm_out_d     = pwm_out_q;
    period_tick_d = 1'b0;
    update_ack_d  = 1'b0;
    tick          = 1'b0;
    boundary      = 1'b0;
    load          = 1'b0;

    if (!bus.enable) begin
      presc_cnt_d = '0;
      cnt_d       = '0;
      dir_d       = DIR_UP;
      pwm_out_d   = pol_a_q;
      load        = pending_q | bus.update;
    end else begin
      // >= rather than == so a live prescale reduction never stalls for a full wrap
      if (presc_cnt_q >= bus.prescale) begin
        tick        = 1'b1;
        presc_cnt_d = '0;
      end else begin
        presc_cnt_d = presc_cnt_q + 1'b1;
      end

      if (tick) begin
        if (period_a_q == '0) begin
          boundary = 1'b1;
          cnt_d    = '0;
          dir_d    = DIR_UP;
        end else if (mode_a_q == MODE_EDGE) begin
          dir_d = DIR_UP;
          if (cnt_q == period_a_q) begin
            boundary = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (dir_q == DIR_UP) begin
          if (cnt_q == period_a_q) begin
            dir_d = DIR_DOWN;
            cnt_d = cnt_q - 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          if (cnt_q == N'(1)) begin
            boundary = 1'b1;
            dir_d    = DIR_UP;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      pwm_out_d     = raw ^ pol_a_q;
      period_tick_d = boundary;
      load          = boundary & (pending_q | bus.update);
    end

    // Ports are sampled at load time, so repeated update pulses collapse into one load
    if (load) begin
      period_a_d   = bus.period;
      duty_a_d     = bus.duty;
      pol_a_d      = bus.polarity;
      mode_a_d     = mode_e'(bus.center_mode);
      dir_d        = DIR_UP;
      pending_d    = 1'b0;
      update_ack_d = 1'b1;
    end else begin
      pending_d = pending_q | bus.update;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt_q   <= '0;
      cnt_q         <= '0;
      dir_q         <= DIR_UP;
      pending_q     <= 1'b0;
      period_a_q    <= '1;
      duty_a_q      <= '0;
      pol_a_q       <= '0;
      mode_a_q      <= MODE_EDGE;
      pwm_out_q     <= '0;
      period_tick_q <= 1'b0;
      update_ack_q  <= 1'b0;
    end else begin
      presc_cnt_q   <= presc_cnt_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      pending_q     <= pending_d;
      period_a_q    <= period_a_d;
      duty_a_q      <= duty_a_d;
      pol_a_q       <= pol_a_d;
      mode_a_q      <= mode_a_d;
      pwm_out_q     <= pwm_out_d;
      period_tick_q <= period_tick_d;
      update_ack_q  <= update_ack_d;
    end
  end

  assign bus.pwm_out     = pwm_out_q;
  assign bus.period_tick = period_tick_q;
  assign bus.update_ack  = update_ack_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench for pwm_multi_channel: expected tick/ack events with
// per-period high counts are queued by the stimulus and checked by a monitor.
module tb_pwm_multi_channel;

  localparam int N  = 8;
  localparam int CH = 4;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  pwm_multi_channel_if #(.N(N), .CH(CH), .PRESC_W(PW)) bus_if ();

  pwm_multi_channel #(.N(N), .CH(CH), .PRESC_W(PW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               tick;
    bit               ack;
    bit               chk;
    int               spacing;
    logic [3:0][7:0]  highs;
  } exp_t;

  exp_t            sb[$];
  int              checks = 0;
  int              passes = 0;
  int              win_cycles = 0;
  logic [3:0][7:0] win_highs = '0;

  // Each tick/ack event closes the observation window opened by the previous one
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   ok;
    if (reset_n && (bus_if.period_tick || bus_if.update_ack)) begin
      checks++;
      if (sb.size() == 0) begin
        $display("[TB] FAIL unexpected_event: got tick=%0b ack=%0b, required no event",
                 bus_if.period_tick, bus_if.update_ack);
      end else begin
        e  = sb.pop_front();
        ok = (bus_if.period_tick == e.tick) && (bus_if.update_ack == e.ack);
        if (e.chk) ok = ok && (win_cycles == e.spacing) && (win_highs == e.highs);
        if (ok) passes++;
        else $display("[TB] FAIL event: got tick=%0b ack=%0b spacing=%0d highs=%h, required tick=%0b ack=%0b spacing=%0d highs=%h (chk=%0b)",
                      bus_if.period_tick, bus_if.update_ack, win_cycles, win_highs,
                      e.tick, e.ack, e.spacing, e.highs, e.chk);
      end
      win_cycles = 1;
      for (int k = 0; k < CH; k++) win_highs[k] = 8'(bus_if.pwm_out[k]);
    end else begin
      win_cycles++;
      for (int k = 0; k < CH; k++) win_highs[k] = win_highs[k] + 8'(bus_if.pwm_out[k]);
    end
    if (!bus_if.enable) begin
      win_cycles = 0;
      win_highs  = '0;
    end
  end

  task automatic pushEvent(bit tick, bit ack, bit chk, int spacing, logic [3:0][7:0] highs);
    exp_t e;
    e.tick = tick; e.ack = ack; e.chk = chk; e.spacing = spacing; e.highs = highs;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(logic [PW-1:0] psc, logic [N-1:0] per, logic cm,
                               logic [CH*N-1:0] dty, logic [CH-1:0] pol, bit do_update);
    bus_if.prescale    = psc;
    bus_if.period      = per;
    bus_if.center_mode = cm;
    bus_if.duty        = dty;
    bus_if.polarity    = pol;
    if (do_update) begin
      bus_if.update = 1'b1;
      @(posedge clk);
      #1 bus_if.update = 1'b0;
    end
  endtask

  task automatic checkOutput(string name, logic [5:0] actual, logic [5:0] required);
    checks++;
    if (actual === required) passes++;
    else $display("[TB] FAIL %s: got %b, required %b", name, actual, required);
  endtask

  task automatic waitDrain(string name, int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() == 0) passes++;
    else begin
      $display("[TB] FAIL drain_%s: got %0d events outstanding, required 0", name, sb.size());
      sb.delete();
    end
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bus_if.enable      = 1'b0;
    bus_if.prescale    = '0;
    bus_if.period      = '0;
    bus_if.center_mode = 1'b0;
    bus_if.duty        = '0;
    bus_if.polarity    = '0;
    bus_if.update      = 1'b0;

    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Idle after reset: everything low, no events
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 checkOutput("reset_idle", {bus_if.pwm_out, bus_if.period_tick, bus_if.update_ack}, 6'b0);
    end

    $display("[TB] edge-aligned basic");
    pushEvent(1'b0, 1'b1, 1'b0, 0, '0);
    applyStimulus(8'd0, 8'd9, 1'b0, {8'd5, 8'd10, 8'd0, 8'd3}, 4'b0000, 1'b1);
    waitDrain("edge_load", 5);
    pushEvent(1'b1, 1'b0, 1'b0, 0, '0);
    pushEvent(1'b1, 1'b0, 1'b1, 10, {8'd5, 8'd10, 8'd0, 8'd3});
    pushEvent(1'b1, 1'b0, 1'b1, 10, {8'd5, 8'd10, 8'd0, 8'd3});
    bus_if.enable = 1'b1;
    waitDrain("edge_run", 100);
    bus_if.enable = 1'b0;

    $display("[TB] prescaler");
    applyStimulus(8'd3, 8'd9, 1'b0, {8'd5, 8'd10, 8'd0, 8'd3}, 4'b0000, 1'b0);
    pushEvent(1'b1, 1'b0, 1'b0, 0, '0);
    pushEvent(1'b1, 1'b0, 1'b1, 40, {8'd20, 8'd40, 8'd0, 8'd12});
    pushEvent(1'b1, 1'b0, 1'b1, 40, {8'd20, 8'd40, 8'd0, 8'd12});
    @(posedge clk);
    #1 bus_if.enable = 1'b1;
    waitDrain("presc_run", 300);
    bus_if.enable = 1'b0;

    $display("[TB] center-aligned");
    pushEvent(1'b0, 1'b1, 1'b0, 0, '0);
    applyStimulus(8'd0, 8'd4, 1'b1, {8'd5, 8'd10, 8'd0, 8'd2}, 4'b0000, 1'b1);
    waitDrain("center_load", 5);
    pushEvent(1'b1, 1'b0, 1'b0, 0, '0);
    pushEvent(1'b1, 1'b0, 1'b1, 8, {8'd8, 8'd8, 8'd0, 8'd3});
    pushEvent(1'b1, 1'b0, 1'b1, 8, {8'd8, 8'd8, 8'd0, 8'd3});
    bus_if.enable = 1'b1;
    waitDrain("center_run", 100);
    bus_if.enable = 1'b0;

    $display("[TB] glitch-free update");
    pushEvent(1'b0, 1'b1, 1'b0, 0, '0);
    applyStimulus(8'd0, 8'd9, 1'b0, {8'd5, 8'd10, 8'd0, 8'd3}, 4'b0000, 1'b1);
    waitDrain("glitch_load", 5);
    pushEvent(1'b1, 1'b0, 1'b0, 0, '0);
    pushEvent(1'b1, 1'b1, 1'b1, 10, {8'd5, 8'd10, 8'd0, 8'd3});
    pushEvent(1'b1, 1'b0, 1'b1, 10, {8'd5, 8'd10, 8'd0, 8'd7});
    bus_if.enable = 1'b1;
    for (int i = 0; i < 50 && sb.size() > 2; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    // cnt is 4 here: request the new duty mid-period, then pulse update again
    #1;
    bus_if.duty   = {8'd5, 8'd10, 8'd0, 8'd7};
    bus_if.update = 1'b1;
    @(posedge clk);
    #1 bus_if.update = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus_if.update = 1'b1;
    @(posedge clk);
    #1 bus_if.update = 1'b0;
    waitDrain("glitch_run", 100);
    bus_if.enable = 1'b0;

    $display("[TB] polarity, disable, async reset");
    pushEvent(1'b0, 1'b1, 1'b0, 0, '0);
    applyStimulus(8'd0, 8'd9, 1'b0, {8'd5, 8'd10, 8'd0, 8'd7}, 4'b0001, 1'b1);
    waitDrain("pol_load", 5);
    repeat (2) @(posedge clk);
    #1 checkOutput("idle_polarity", {bus_if.pwm_out, bus_if.period_tick, bus_if.update_ack}, 6'b0001_00);
    pushEvent(1'b1, 1'b0, 1'b0, 0, '0);
    pushEvent(1'b1, 1'b0, 1'b1, 10, {8'd5, 8'd10, 8'd0, 8'd3});
    bus_if.enable = 1'b1;
    waitDrain("pol_run", 100);
    repeat (3) @(posedge clk);
    #2 checkOutput("pre_reset_ch2", {5'b0, bus_if.pwm_out[2]}, 6'b000001);
    #1 reset_n = 1'b0;
    #1 checkOutput("async_reset", {bus_if.pwm_out, bus_if.period_tick, bus_if.update_ack}, 6'b0);
    bus_if.enable = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkOutput("post_reset_idle", {bus_if.pwm_out, bus_if.period_tick, bus_if.update_ack}, 6'b0);

    repeat (10) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
